register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_clear_seq.sv | 54 +++++
 rtl/register_file_mp.sv | 87 ++++++++
 tb/tb_register_file_mp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes and clear-FSM encoding.
package regfile_pkg;

  localparam int unsigned DefXlen  = 32;
  localparam int unsigned DefNregs = 32;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps registers 1..NREGS-1 to zero after reset or on request,
// then holds ready high until the next clear.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = DefNregs,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_req_i,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_idx_o
);

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  rf_state_e     state_q;
  logic [AW-1:0] idx_q;
  logic          ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StClear;
      idx_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          // clear_req is deliberately not looked at here so a sweep never restarts
          if (idx_q == LastIdx) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        StIdle: begin
          if (clear_req_i) begin
            state_q <= StClear;
            idx_q   <= AW'(1);
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign clr_we_o  = (state_q == StClear);
  assign clr_idx_o = idx_q;

endmodule

// File: rtl/register_file_mp.sv
// Two-read / one-write register file with x0 hardwired to zero, a zeroing sweep after
// reset or clear_req, optional write-to-read forwarding and a registered debug tap.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN    = DefXlen,
  parameter int unsigned NREGS   = DefNregs,
  parameter int unsigned AW      = $clog2(NREGS),
  parameter bit          BYPASS  = 1'b1,
  parameter int unsigned TAP_REG = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_we,
  input  logic [XLEN-1:0] rd_data,
  input  logic            clear_req,
  output logic            ready,
  output logic [XLEN-1:0] tap_data
);

  localparam logic [AW-1:0] TapAddr = AW'(TAP_REG);

  logic            clr_we;
  logic [AW-1:0]   clr_idx;
  logic            usr_we;
  logic            fwd_en;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] tap_q;

  regfile_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_req_i (clear_req),
    .ready_o     (ready),
    .clr_we_o    (clr_we),
    .clr_idx_o   (clr_idx)
  );

  // A clear request in the same cycle as a write wins and drops the write.
  assign usr_we = ready && rd_we && (rd_addr != '0) && !clear_req;
  assign fwd_en = BYPASS && ready && rd_we && (rd_addr != '0);
  assign we     = rst_n && (clr_we || usr_we);
  assign waddr  = clr_we ? clr_idx : rd_addr;
  assign wdata  = clr_we ? '0 : rd_data;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_q <= '0;
    end else if (we && (waddr == TapAddr)) begin
      tap_q <= wdata;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (ready && (rs1_addr != '0)) begin
      rs1_data = (fwd_en && (rs1_addr == rd_addr)) ? rd_data : mem_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (ready && (rs2_addr != '0)) begin
      rs2_data = (fwd_en && (rs2_addr == rd_addr)) ? rd_data : mem_q[rs2_addr];
    end
  end

  assign tap_data = tap_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one instance with forwarding, one without,
// driven by the same stimulus.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we, clear_req;
  logic [31:0] rd_data;

  logic [31:0] rs1_b, rs2_b, tap_b, rs1_n, rs2_n, tap_n;
  logic        ready_b, ready_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1'b1)) u_byp (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_b),
    .rs2_data  (rs2_b),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .rd_data   (rd_data),
    .clear_req (clear_req),
    .ready     (ready_b),
    .tap_data  (tap_b)
  );

  register_file_mp #(.BYPASS(1'b0)) u_nobyp (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_n),
    .rs2_data  (rs2_n),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .rd_data   (rd_data),
    .clear_req (clear_req),
    .ready     (ready_n),
    .tap_data  (tap_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rd_we = 1'b0; clear_req = 1'b0; rd_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_ready", {31'd0, ready_b}, 32'd0);
    chk("rst_tap", tap_b, 32'd0);
    chk("rst_rs1", rs1_b, 32'd0);

    // Initial sweep: ready rises on the 31st edge after release
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("init_ready", {31'd0, ready_b}, (k == 31) ? 32'd1 : 32'd0);
      chk("init_ready_nb", {31'd0, ready_n}, (k == 31) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i); #1;
      chk("init_rs1", rs1_b, 32'd0);
      chk("init_rs2", rs2_b, 32'd0);
    end

    // Write x7 with forwarding vs. without
    rd_we = 1'b1; rd_addr = 5'd7; rd_data = 32'hDEADBEEF; rs1_addr = 5'd7; #1;
    chk("fwd_same_cycle", rs1_b, 32'hDEADBEEF);
    chk("nofwd_same_cycle", rs1_n, 32'd0);
    tick();
    rd_we = 1'b0; #1;
    chk("nofwd_next_cycle", rs1_n, 32'hDEADBEEF);
    chk("fwd_next_cycle", rs1_b, 32'hDEADBEEF);

    // Write to x0 is discarded and never forwarded
    rd_we = 1'b1; rd_addr = 5'd0; rd_data = 32'h12345678; rs1_addr = 5'd0; #1;
    chk("x0_same_cycle", rs1_b, 32'd0);
    tick();
    rd_we = 1'b0; #1;
    chk("x0_after", rs1_b, 32'd0);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); #1;
      chk("x0_no_side_effect", rs1_b, (i == 7) ? 32'hDEADBEEF : 32'd0);
    end

    // Tap mirror, then clear sweep zeroes it on the edge that clears x5
    rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'h000000A5; #1;
    chk("tap_before_edge", tap_b, 32'd0);
    tick();
    rd_we = 1'b0; #1;
    chk("tap_after_write", tap_b, 32'h000000A5);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0; rs2_addr = 5'd7; #1;
    chk("clr_ready_low", {31'd0, ready_b}, 32'd0);
    chk("clr_read_gated", rs2_b, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("clr_ready", {31'd0, ready_b}, (k == 31) ? 32'd1 : 32'd0);
      chk("clr_tap", tap_b, (k < 5) ? 32'h000000A5 : 32'd0);
    end
    chk("clr_x7_zero", rs2_b, 32'd0);

    // Clear and write together; second clear and a write mid-sweep are ignored
    clear_req = 1'b1; rd_we = 1'b1; rd_addr = 5'd3; rd_data = 32'h55;
    tick();
    clear_req = 1'b0; rd_we = 1'b0; #1;
    chk("cw_ready_low", {31'd0, ready_b}, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("cw_ready", {31'd0, ready_b}, (k == 31) ? 32'd1 : 32'd0);
      clear_req = (k == 10);
      if (k == 20) begin
        rd_we = 1'b1; rd_addr = 5'd9; rd_data = 32'h99; rs1_addr = 5'd9; #1;
        chk("cw_no_fwd_not_ready", rs1_b, 32'd0);
      end else begin
        rd_we = 1'b0;
      end
    end
    rs1_addr = 5'd3; rs2_addr = 5'd9; #1;
    chk("cw_x3_zero", rs1_b, 32'd0);
    chk("cw_x9_zero", rs2_b, 32'd0);

    // Reset at sweep index 10 restarts a full sweep; rd_we to the tap register ignored
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0; rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'h77;
    for (int k = 1; k <= 9; k++) tick();
    rst_n = 1'b0;
    tick(); tick();
    chk("midrst_ready", {31'd0, ready_b}, 32'd0);
    chk("midrst_tap", tap_b, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk("midrst_sweep_ready", {31'd0, ready_b}, (k == 31) ? 32'd1 : 32'd0);
      chk("midrst_sweep_tap", tap_b, 32'd0);
    end
    rd_we = 1'b0; rs1_addr = 5'd5; #1;
    chk("midrst_x5_zero", rs1_b, 32'd0);
    chk("midrst_tap_after", tap_b, 32'd0);

    // Top register boundary
    rd_we = 1'b1; rd_addr = 5'd31; rd_data = 32'hFFFFFFFF;
    tick();
    rd_we = 1'b0; rs1_addr = 5'd31; rs2_addr = 5'd1; #1;
    chk("x31_write", rs1_n, 32'hFFFFFFFF);
    chk("x1_untouched", rs2_n, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
